// File: rtl/nearest_mean_sched.sv
// -----------------------------------------------------------------------------
// nearest_mean_sched
//
// Picks the byte lane of a 32-bit word (four LANE_W lanes) whose value is
// closest to the mean of the four lanes. Two requesters share one engine
// through a round-robin arbiter. A single abs-deviation/compare unit walks
// the lanes one per cycle.
//
//   IDLE -> SUM (1 cycle) -> EVAL (4 cycles, lane 0..3) -> DONE -> IDLE
//
// The mean comparison is done as |4*lane - sum|, which has the same ordering
// as |lane - mean| and needs no divider. Ties resolve to the lowest lane.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid0/din0/in_ready0  requester 0 word handshake
//   in_valid1/din1/in_ready1  requester 1 word handshake
//   out_valid/out_ready   result handshake
//   result                winning lane index
//   result_id             requester that supplied the word
//   min_dev               winning |4*lane - sum|, only when the
//                         NEAREST_MEAN_DEV_OUT_EN macro is defined
// -----------------------------------------------------------------------------
module nearest_mean_sched #(
   parameter int LANE_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid0,
   input  logic [4*LANE_W-1:0] din0,
   output logic                in_ready0,
   input  logic                in_valid1,
   input  logic [4*LANE_W-1:0] din1,
   output logic                in_ready1,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [1:0]          result,
   output logic                result_id
`ifdef NEAREST_MEAN_DEV_OUT_EN
   ,output logic [LANE_W+1:0]  min_dev
`endif
);

   localparam int WORD_W = 4 * LANE_W;
   localparam int SUM_W  = LANE_W + 2;
   localparam int DIFF_W = LANE_W + 3;

   typedef enum logic [1:0] {IDLE, SUM, EVAL, DONE} state_t;

   state_t              state_q, state_d;
   logic [1:0]          lane_q, lane_d;
   logic                prio_q, prio_d;      // requester favoured when both are valid
   logic [WORD_W-1:0]   word_q, word_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [SUM_W-1:0]    min_q, min_d;
   logic [1:0]          idx_q, idx_d;
   logic                out_valid_q, out_valid_d;
   logic [1:0]          result_q, result_d;
   logic                result_id_q, result_id_d;
`ifdef NEAREST_MEAN_DEV_OUT_EN
   logic [SUM_W-1:0]    min_dev_q, min_dev_d;
`endif

   // Arbitration: a lone requester always wins; on contention the one
   // holding priority wins and priority then passes to the other side.
   logic grant_any, grant_id;
   assign grant_any = in_valid0 | in_valid1;
   assign grant_id  = (in_valid0 & in_valid1) ? prio_q : in_valid1;

   assign in_ready0 = (state_q == IDLE) & grant_any & ~grant_id;
   assign in_ready1 = (state_q == IDLE) & grant_any &  grant_id;

   // Shared deviation unit for the lane selected by lane_q.
   logic [LANE_W-1:0]        lane_val;
   logic signed [DIFF_W-1:0] diff, abs_full;
   logic [SUM_W-1:0]         dev;
   logic [SUM_W-1:0]         sum_acc;

   always_comb begin
      lane_val = word_q[int'(lane_q)*LANE_W +: LANE_W];
      diff     = $signed({1'b0, lane_val, 2'b00}) - $signed({1'b0, sum_q});
      abs_full = diff[DIFF_W-1] ? -diff : diff;
      dev      = abs_full[SUM_W-1:0];
      sum_acc  = '0;
      for (int i = 0; i < 4; i++) begin
         sum_acc = sum_acc + SUM_W'(word_q[i*LANE_W +: LANE_W]);
      end
   end

   always_comb begin
      // NOTE: every _d starts from its _q so no path leaves a value unassigned;
      // a missing default here would infer a latch.
      state_d     = state_q;
      lane_d      = lane_q;
      prio_d      = prio_q;
      word_d      = word_q;
      sum_d       = sum_q;
      min_d       = min_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      result_id_d = result_id_q;
`ifdef NEAREST_MEAN_DEV_OUT_EN
      min_dev_d   = min_dev_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (grant_any) begin
               word_d      = grant_id ? din1 : din0;
               result_id_d = grant_id;
               prio_d      = ~grant_id;
               state_d     = SUM;
            end
         end
         SUM: begin
            sum_d   = sum_acc;
            lane_d  = 2'd0;
            state_d = EVAL;
         end
         EVAL: begin
            // Lane 0 seeds the running minimum; later lanes replace it only on
            // a strictly smaller deviation, so ties keep the lower index.
            if (lane_q == 2'd0 || dev < min_q) begin
               min_d = dev;
               idx_d = lane_q;
            end
            lane_d = lane_q + 2'd1;
            if (lane_q == 2'd3) begin
               result_d    = idx_d;
               out_valid_d = 1'b1;
`ifdef NEAREST_MEAN_DEV_OUT_EN
               min_dev_d   = min_d;
`endif
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the datapath registers are reset too (not only control), so
         // a discarded job leaves nothing behind that could leak into the next.
         state_q     <= IDLE;
         lane_q      <= 2'd0;
         prio_q      <= 1'b0;
         word_q      <= '0;
         sum_q       <= '0;
         min_q       <= '0;
         idx_q       <= 2'd0;
         out_valid_q <= 1'b0;
         result_q    <= 2'd0;
         result_id_q <= 1'b0;
`ifdef NEAREST_MEAN_DEV_OUT_EN
         min_dev_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         prio_q      <= prio_d;
         word_q      <= word_d;
         sum_q       <= sum_d;
         min_q       <= min_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         result_id_q <= result_id_d;
`ifdef NEAREST_MEAN_DEV_OUT_EN
         min_dev_q   <= min_dev_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign result_id = result_id_q;
`ifdef NEAREST_MEAN_DEV_OUT_EN
   assign min_dev   = min_dev_q;
`endif

endmodule

// File: tb/tb_nearest_mean_sched.sv
// -----------------------------------------------------------------------------
// tb_nearest_mean_sched
//
// Directed plus randomized jobs for nearest_mean_sched. Expected lane, owner
// and deviation come from a plain arithmetic model of the "nearest to the
// mean" rule and a round-robin priority token kept here.
// -----------------------------------------------------------------------------
module tb_nearest_mean_sched;

   localparam int LANE_W = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid0, in_valid1;
   logic [31:0] din0, din1;
   logic        in_ready0, in_ready1;
   logic        out_valid, out_ready;
   logic [1:0]  result;
   logic        result_id;
`ifdef NEAREST_MEAN_DEV_OUT_EN
   logic [LANE_W+1:0] min_dev;
`endif

   nearest_mean_sched #(.LANE_W(LANE_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid0 (in_valid0),
      .din0      (din0),
      .in_ready0 (in_ready0),
      .in_valid1 (in_valid1),
      .din1      (din1),
      .in_ready1 (in_ready1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_id (result_id)
`ifdef NEAREST_MEAN_DEV_OUT_EN
      ,.min_dev  (min_dev)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int prio  = 0;   // requester that wins the next contended arbitration

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: lane whose value is closest to the mean of the four lanes,
   // lowest index on ties; dev is |4*lane - sum|.
   function automatic void ref_nearest(input logic [31:0] w, output int idx, output int dev);
      int lanes[4];
      int s = 0;
      for (int i = 0; i < 4; i++) begin
         lanes[i] = int'((w >> (8 * i)) & 32'hFF);
         s += lanes[i];
      end
      idx = 0;
      dev = 0;
      for (int i = 0; i < 4; i++) begin
         int d = 4 * lanes[i] - s;
         if (d < 0) d = -d;
         if (i == 0 || d < dev) begin
            dev = d;
            idx = i;
         end
      end
   endfunction

   // One full job from IDLE: arbitration, latency, result, optional hold in
   // DONE, handshake. With keep set the input valids stay high while busy.
   task automatic do_job(input bit v0, input bit v1, input logic [31:0] w0,
                         input logic [31:0] w1, input int hold, input bit keep);
      int k, exp_idx, exp_dev, cyc;
      k = (v0 && v1) ? prio : (v1 ? 1 : 0);
      ref_nearest(k ? w1 : w0, exp_idx, exp_dev);
      in_valid0 = v0;
      in_valid1 = v1;
      din0      = w0;
      din1      = w1;
      out_ready = 1'b0;
      #1;
      check("in_ready0_idle", in_ready0, (k == 0));
      check("in_ready1_idle", in_ready1, (k == 1));
      step();
      prio = 1 - k;
      if (!keep) begin
         in_valid0 = 1'b0;
         in_valid1 = 1'b0;
         din0      = $urandom;
         din1      = $urandom;
      end
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 12) begin
         check("busy_ready", {in_ready0, in_ready1}, 2'b00);
         step();
         cyc++;
      end
      check("latency", cyc, 5);
      check("result", result, exp_idx);
      check("result_id", result_id, k);
`ifdef NEAREST_MEAN_DEV_OUT_EN
      check("min_dev", min_dev, exp_dev);
`endif
      for (int h = 0; h < hold; h++) begin
         step();
         check("hold_valid", out_valid, 1'b1);
         check("hold_result", result, exp_idx);
         check("hold_id", result_id, k);
         check("hold_ready", {in_ready0, in_ready1}, 2'b00);
`ifdef NEAREST_MEAN_DEV_OUT_EN
         check("hold_min_dev", min_dev, exp_dev);
`endif
      end
      out_ready = 1'b1;
      #1;
      check("handshake_ready", {in_ready0, in_ready1}, 2'b00);
      step();
      out_ready = 1'b0;
      check("post_handshake_valid", out_valid, 1'b0);
   endtask

   initial begin
      int idx_dummy, dev_dummy;
      rst_n     = 1'b0;
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      din0      = '0;
      din1      = '0;
      out_ready = 1'b0;
      step();
      step();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_result", result, 2'd0);
      check("rst_result_id", result_id, 1'b0);
      rst_n = 1'b1;
      #1;
      check("rst_ready_idle", {in_ready0, in_ready1}, 2'b00);

      // Directed words from the plan.
      do_job(1'b1, 1'b0, 32'h10203040, 32'h0, 0, 1'b0);
      do_job(1'b1, 1'b0, 32'h55555555, 32'h0, 0, 1'b0);
      do_job(1'b0, 1'b1, 32'hDEADBEEF, 32'h00FF0080, 0, 1'b0);

      // Contention back-to-back: a fresh reset favours req0, then alternates.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      prio  = 0;
      do_job(1'b1, 1'b1, 32'h01020304, 32'hA0B0C0D0, 0, 1'b1);
      do_job(1'b1, 1'b1, 32'h01020304, 32'hA0B0C0D0, 0, 1'b1);
      do_job(1'b1, 1'b1, 32'h11223344, 32'h80808001, 0, 1'b1);

      // Consumer stalls for 10 cycles in DONE.
      do_job(1'b1, 1'b0, 32'h7F00FF01, 32'h0, 10, 1'b0);

      // Reset while the engine is on lane 2 of EVAL.
      in_valid0 = 1'b1;
      in_valid1 = 1'b1;
      din0      = $urandom;
      din1      = $urandom;
      step();                    // accept
      step();                    // SUM done, EVAL lane 0
      step();                    // lane 1
      step();                    // lane 2
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      prio  = 0;
      #1;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_ready0", in_ready0, 1'b1);
      check("abort_ready1", in_ready1, 1'b0);
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         check("abort_no_result", out_valid, 1'b0);
      end
      do_job(1'b1, 1'b1, 32'h40404040, 32'h01FE01FE, 0, 1'b0);

      // Randomized jobs; half use small lane values to provoke ties.
      for (int i = 0; i < 24; i++) begin
         logic [1:0]  pat;
         logic [31:0] w0, w1;
         pat = 2'($urandom_range(1, 3));
         if (i % 2 == 0) begin
            w0 = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                  8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
            w1 = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                  8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
         end else begin
            w0 = $urandom;
            w1 = $urandom;
         end
         do_job(pat[0], pat[1], w0, w1, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      ref_nearest(32'h0, idx_dummy, dev_dummy);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
